// File: rtl/comparator_pkg.sv
// Shared types and elaboration helpers for the bit-serial constant-time comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must hold 0..STEPS-1; a single-step scan still needs one bit.
  function automatic int cnt_width(input int width, input int digit);
    int s;
    s = steps(width, digit);
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/cmp_digit_lt.sv
// One digit of the LSB-first magnitude scan: the current digit overrides the
// running result unless the digits are equal.
module cmp_digit_lt #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  input  logic             lt_in,
  input  logic             eq_in,
  output logic             lt_out,
  output logic             eq_out
);

  assign lt_out = (da < db) | ((da == db) & lt_in);
  assign eq_out = eq_in & (da == db);

endmodule

// File: rtl/comparator_32bit_serial_lt.sv
// Bit-serial unsigned comparator: always scans WIDTH/DIGIT cycles with no early
// exit, then presents one-hot lt/eq/gt over a valid/ready handshake.
module comparator_32bit_serial_lt
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             busy
);

  localparam bit PARAM_OK = (DIGIT >= 1) && (DIGIT <= WIDTH) &&
                            ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) == 0);
  localparam int STEPS    = PARAM_OK ? steps(WIDTH, DIGIT) : 1;
  localparam int CW       = PARAM_OK ? cnt_width(WIDTH, DIGIT) : 1;

  if (!PARAM_OK) begin : g_bad_params
    $error("comparator_32bit_serial_lt: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sa, sb;
  logic [CW-1:0]     cnt;
  logic              lt, eq;
  logic              lt_step, eq_step;
  logic              last_step;

  cmp_digit_lt #(.DIGIT(DIGIT)) u_digit (
    .da     (sa[DIGIT-1:0]),
    .db     (sb[DIGIT-1:0]),
    .lt_in  (lt),
    .eq_in  (eq),
    .lt_out (lt_step),
    .eq_out (eq_step)
  );

  assign last_step = (cnt == CW'(STEPS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path through
  // this block leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      lt  <= 1'b0;
      eq  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa  <= in_a;
          sb  <= in_b;
          cnt <= '0;
          lt  <= 1'b0;
          eq  <= 1'b1;
        end
        RUN: begin
          sa  <= sa >> DIGIT;
          sb  <= sb >> DIGIT;
          cnt <= cnt + 1'b1;
          lt  <= lt_step;
          eq  <= eq_step;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registers, so no combinational path from any input.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_lt    = out_valid & lt;
  assign out_eq    = out_valid & eq;
  assign out_gt    = out_valid & ~lt & ~eq;

endmodule

// File: tb/tb_comparator_32bit_serial_lt.sv
// Self-checking bench: directed cases plus randomized operands against a plain
// arithmetic reference, on DIGIT=1, 4 and 32 builds.
module tb_comparator_32bit_serial_lt;

  localparam int STEPS = 32;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        out_lt, out_eq, out_gt, busy;

  logic iv4, rdy4, ov4, or4, lt4, eq4, gt4, busy4;
  logic iv32, rdy32, ov32, or32, lt32, eq32, gt32, busy32;

  int n_checks, n_fail;

  comparator_32bit_serial_lt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt), .busy(busy)
  );

  comparator_32bit_serial_lt #(.WIDTH(32), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4),
    .in_a(in_a), .in_b(in_b), .out_valid(ov4), .out_ready(or4),
    .out_lt(lt4), .out_eq(eq4), .out_gt(gt4), .busy(busy4)
  );

  comparator_32bit_serial_lt #(.WIDTH(32), .DIGIT(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
    .in_a(in_a), .in_b(in_b), .out_valid(ov32), .out_ready(or32),
    .out_lt(lt32), .out_eq(eq32), .out_gt(gt32), .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: flags straight from unsigned arithmetic, packed {lt,eq,gt}.
  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    if (a < b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit noise);
    int guard, lat;
    logic [2:0] exp;
    exp = ref_flags(a, b);
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = $urandom; in_b = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, STEPS);
    check({tag, "_flags"}, {out_lt, out_eq, out_gt}, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_flags"}, {out_valid, out_lt, out_eq, out_gt}, {1'b1, exp});
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_after"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    n_checks = 0; n_fail = 0;
    in_valid = 0; out_ready = 0; in_a = 0; in_b = 0;
    iv4 = 0; or4 = 0; iv32 = 0; or32 = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, out_valid, out_lt, out_eq, out_gt, busy}, 6'b100000);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("lt_1_2", 32'h1, 32'h2, 0, 0);
    run_op("gt_msb", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 0);
    run_op("eq_dead", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    run_op("hold10", 32'h0000_0010, 32'h0000_0100, 10, 0);

    // Abort mid-scan: reset during RUN must suppress the result.
    in_a = 32'h0000_0003; in_b = 32'h0000_0009; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("abort_busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #2;
    check("abort_async", {in_ready, out_valid, busy}, 3'b100);
    #2 rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("abort_no_result", lat, 0);
    run_op("eq_5_5", 32'd5, 32'd5, 0, 0);

    // DIGIT=4 build.
    in_a = 32'h8000_0000; in_b = 32'h0000_0001; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; lat = 0;
    while (!ov4 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("d4_latency", lat, 8);
    check("d4_flags", {lt4, eq4, gt4, busy4}, 4'b0011);
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
    check("d4_idle_after", {rdy4, ov4}, 2'b10);

    // DIGIT=WIDTH build.
    iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; lat = 0;
    while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("d32_latency", lat, 1);
    check("d32_flags", {lt32, eq32, gt32, busy32}, 4'b0011);
    or32 = 1'b1; @(posedge clk); #1; or32 = 1'b0;
    check("d32_idle_after", {rdy32, ov32}, 2'b10);

    // Random pairs, biased toward equal and near-equal operands.
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      run_op("rand", a, b, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
